// File: rtl/jk_drv_pkg.sv
// jk_drv_pkg: shared op encodings and FSM state type for the JK bank driver
package jk_drv_pkg;
  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
endpackage

// File: rtl/jk_excite.sv
// jk_excite: minimal J/K excitation that moves a JK bank from state q to target t
// Ports: i_q current state, i_t target state, i_toggle use toggle path,
//        o_j / o_k per-bit excitation (unchanged bits hold with J=K=0).
module jk_excite #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_t,
  input  logic             i_toggle,
  output logic [WIDTH-1:0] o_j,
  output logic [WIDTH-1:0] o_k
);
  logic [WIDTH-1:0] w_flip;
  // For a toggle the target is q^mask, so q^t recovers the mask exactly.
  assign w_flip = i_q ^ i_t;
  assign o_j = i_toggle ? w_flip : i_t & ~i_q;
  assign o_k = i_toggle ? w_flip : ~i_t & i_q;
endmodule

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: turns load/set/clear/toggle commands into one-cycle J/K drive and checks Q feedback
// Ports: clock/reset (async, active-high) shared with the bank; cmd_valid/cmd_ready/cmd_op/cmd_data
//        command handshake; j/k registered excitation; q_fb bank feedback; shadow_q expected bank
//        state; busy in DRIVE/CHECK; done pulse in CHECK; err sticky mismatch, cleared by err_clr.
module jk_bank_driver
  import jk_drv_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] shadow_q,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             err_clr
);
  state_t           r_state;
  logic [WIDTH-1:0] r_j, r_k, r_shadow;
  logic             r_done, r_err;
  logic [WIDTH-1:0] w_t, w_j, w_k;
  logic             w_mismatch;
  always_comb
    w_t = cmd_op == OP_LOAD  ? cmd_data :
          cmd_op == OP_SET   ? r_shadow | cmd_data :
          cmd_op == OP_CLEAR ? r_shadow & ~cmd_data :
                               r_shadow ^ cmd_data;
  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .i_q      (r_shadow),
    .i_t      (w_t),
    .i_toggle (cmd_op == OP_TOGGLE),
    .o_j      (w_j),
    .o_k      (w_k)
  );
  assign w_mismatch = CHECK_EN && r_state == CHECK && q_fb != r_shadow;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_j      <= '0;
      r_k      <= '0;
      r_shadow <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (cmd_valid) begin
            r_shadow <= w_t;
            r_j      <= w_j;
            r_k      <= w_k;
            r_state  <= DRIVE;
          end
        end
        DRIVE: begin
          r_j     <= '0;
          r_k     <= '0;
          r_done  <= 1'b1;
          r_state <= CHECK;
        end
        CHECK: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      // A fresh mismatch takes priority over a simultaneous clear.
      r_err <= w_mismatch ? 1'b1 : err_clr ? 1'b0 : r_err;
    end
  end
  assign j         = r_j;
  assign k         = r_k;
  assign shadow_q  = r_shadow;
  assign done      = r_done;
  assign err       = CHECK_EN ? r_err : 1'b0;
  assign busy      = r_state != IDLE;
  assign cmd_ready = r_state == IDLE;
endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: directed scoreboard bench with a JK flip-flop bank model on the feedback path
module tb_jk_bank_driver;
  typedef struct packed {
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] t;
    logic [7:0] qfb;
  } exp_t;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic [7:0] j, k, q_fb, shadow_q;
  logic       busy, done, err;
  logic       err_clr = 1'b0;
  logic [7:0] bank;
  logic [7:0] stuck = 8'h00;
  logic [7:0] m_q = 8'h00;
  exp_t       sb[$];
  exp_t       cur;
  logic       have_cur = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         acc[$];
  jk_bank_driver #(.WIDTH(8), .CHECK_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .j(j), .k(k), .q_fb(q_fb),
    .shadow_q(shadow_q), .busy(busy), .done(done), .err(err), .err_clr(err_clr)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  always_ff @(posedge clock or posedge reset)
    if (reset) bank <= 8'h00;
    else bank <= (j & ~bank) | (~k & bank);
  assign q_fb = bank & ~stuck;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  always @(negedge clock) begin
    if (reset) have_cur = 1'b0;
    else begin
      chk("ready_vs_busy", {7'd0, cmd_ready}, {7'd0, ~busy});
      if (busy && !done) begin
        chk("drive_has_exp", {7'd0, sb.size() > 0}, 8'd1);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          have_cur = 1'b1;
          chk("drive_j", j, cur.j);
          chk("drive_k", k, cur.k);
        end
      end else chk("jk_zero_outside_drive", j | k, 8'h00);
      if (done) begin
        chk("done_has_exp", {7'd0, have_cur}, 8'd1);
        if (have_cur) begin
          chk("check_shadow", shadow_q, cur.t);
          chk("check_qfb", q_fb, cur.qfb);
          chk("check_busy", {7'd0, busy}, 8'd1);
        end
        have_cur = 1'b0;
      end
    end
  end
  // Call at a negedge; returns at the negedge of the DRIVE cycle.
  task automatic issue(input logic [1:0] op, input logic [7:0] d);
    exp_t e;
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("ready_wait", {7'd0, cmd_ready}, 8'd1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    case (op)
      2'b00: e.t = d;
      2'b01: e.t = m_q | d;
      2'b10: e.t = m_q & ~d;
      default: e.t = m_q ^ d;
    endcase
    e.j = op == 2'b11 ? d : e.t & ~m_q;
    e.k = op == 2'b11 ? d : ~e.t & m_q;
    e.qfb = e.t & ~stuck;
    m_q = e.t;
    sb.push_back(e);
    acc.push_back(cyc);
    @(negedge clock);
  endtask
  task automatic finish_op();
    cmd_valid = 1'b0;
    repeat (2) @(negedge clock);
  endtask
  initial begin
    #3;
    chk("rst_j", j, 8'h00);
    chk("rst_k", k, 8'h00);
    chk("rst_shadow", shadow_q, 8'h00);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_err", {7'd0, err}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_ready", {7'd0, cmd_ready}, 8'd1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    issue(2'b00, 8'hA5); finish_op();
    chk("load_err", {7'd0, err}, 8'd0);
    chk("load_bank", q_fb, 8'hA5);
    issue(2'b11, 8'h0F); finish_op();
    chk("toggle_bank", q_fb, 8'hAA);
    issue(2'b01, 8'h50); finish_op();
    chk("set_bank", q_fb, 8'hFA);
    issue(2'b10, 8'hF0); finish_op();
    chk("clear_bank", q_fb, 8'h0A);
    chk("clean_err", {7'd0, err}, 8'd0);
    stuck = 8'h01;
    issue(2'b00, 8'h01); finish_op();
    chk("stuck_err_set", {7'd0, err}, 8'd1);
    stuck = 8'h00;
    issue(2'b11, 8'h00); finish_op();
    chk("err_sticky", {7'd0, err}, 8'd1);
    chk("mask0_shadow", shadow_q, 8'h01);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    chk("err_cleared", {7'd0, err}, 8'd0);
    stuck = 8'h01;
    issue(2'b01, 8'h00);
    err_clr = 1'b1;
    finish_op();
    chk("set_wins_over_clr", {7'd0, err}, 8'd1);
    err_clr = 1'b0;
    stuck = 8'h00;
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    chk("err_cleared2", {7'd0, err}, 8'd0);
    acc.delete();
    issue(2'b00, 8'h11);
    issue(2'b11, 8'hFF);
    issue(2'b10, 8'hEE);
    finish_op();
    chk("b2b_gap1", 8'(acc[1] - acc[0]), 8'd3);
    chk("b2b_gap2", 8'(acc[2] - acc[1]), 8'd3);
    chk("b2b_shadow", shadow_q, 8'h00);
    chk("b2b_bank", q_fb, 8'h00);
    issue(2'b00, 8'hFF);
    cmd_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("abort_j", j, 8'h00);
    chk("abort_k", k, 8'h00);
    chk("abort_shadow", shadow_q, 8'h00);
    chk("abort_done", {7'd0, done}, 8'd0);
    chk("abort_ready", {7'd0, cmd_ready}, 8'd1);
    m_q = 8'h00;
    sb.delete();
    repeat (2) begin
      @(negedge clock);
      chk("abort_no_done", {7'd0, done}, 8'd0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("post_rst_ready", {7'd0, cmd_ready}, 8'd1);
    chk("post_rst_bank", q_fb, 8'h00);
    chk("post_rst_done", {7'd0, done}, 8'd0);
    chk("post_rst_err", {7'd0, err}, 8'd0);
    issue(2'b11, 8'h3C); finish_op();
    chk("post_rst_toggle", q_fb, 8'h3C);
    chk("sb_drained", 8'(sb.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
